// File: rtl/present_decrypt_if.sv
`default_nettype none
// ============================================================================
//  Module      : present_decrypt_if
//  Description : Load/result bundle for the PRESENT-80 decryption core.
//                master drives load/idat/key and observes odat/done/busy;
//                slave (the core) does the reverse.
//                  load : single-cycle strobe capturing idat and key
//                  idat : 64-bit ciphertext
//                  key  : 80-bit cipher key
//                  odat : 64-bit plaintext, valid while done=1
//                  done : result valid until the next accepted load/reset
//                  busy : high while expanding the key or decrypting
//  Revision    : 1.0 - initial release
// ============================================================================
interface present_decrypt_if;
    logic        load;
    logic [63:0] idat;
    logic [79:0] key;
    logic [63:0] odat;
    logic        done;
    logic        busy;

    modport master (output load, idat, key, input odat, done, busy);
    modport slave  (input load, idat, key, output odat, done, busy);
endinterface
`default_nettype wire

// File: rtl/present_decrypt.sv
`default_nettype none
// ============================================================================
//  Module      : present_decrypt
//  Description : Iterative PRESENT-80 decryption core, one round per clock.
//                A load runs the key schedule forward to K32 (EXPAND), then
//                31 inverse rounds are peeled off (DECRYPT). An optional
//                single-entry cache keeps the last K32 so a reloaded key
//                skips the expansion.
//  Ports       : clk   - rising-edge clock
//                reset - synchronous active-high reset, priority over load
//                bus   - present_decrypt_if.slave (load/idat/key in,
//                        odat/done/busy out)
//  Revision    : 1.0 - initial release
// ============================================================================
module present_decrypt #(
    parameter int KEY_CACHE = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    present_decrypt_if.slave      bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXPAND  = 2'd1,
        DECRYPT = 2'd2,
        DONE    = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Cipher primitives
    // ------------------------------------------------------------------
    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
            4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
            4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
            4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
        endcase
        return y;
    endfunction

    function automatic logic [3:0] inv_sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h5;  4'h1: y = 4'hE;  4'h2: y = 4'hF;  4'h3: y = 4'h8;
            4'h4: y = 4'hC;  4'h5: y = 4'h1;  4'h6: y = 4'h2;  4'h7: y = 4'hD;
            4'h8: y = 4'hB;  4'h9: y = 4'h4;  4'hA: y = 4'h6;  4'hB: y = 4'h3;
            4'hC: y = 4'h0;  4'hD: y = 4'h7;  4'hE: y = 4'h9;  default: y = 4'hA;
        endcase
        return y;
    endfunction

    // Forward key update: rotate left 61, S-box the top nibble, mix in round.
    function automatic logic [79:0] key_fwd(input logic [79:0] k, input logic [4:0] i);
        logic [79:0] r;
        r          = {k[18:0], k[79:19]};
        r[79:76]   = sbox(r[79:76]);
        r[19:15]   = r[19:15] ^ i;
        return r;
    endfunction

    // Inverse key update: undo the steps of key_fwd in reverse order.
    function automatic logic [79:0] key_inv(input logic [79:0] k, input logic [4:0] i);
        logic [79:0] r;
        r          = k;
        r[19:15]   = r[19:15] ^ i;
        r[79:76]   = inv_sbox(r[79:76]);
        return {r[60:0], r[79:61]};
    endfunction

    // The forward pLayer moves bit j to 16j mod 63, so the inverse reads
    // output bit j back from that position.
    function automatic logic [63:0] inv_p(input logic [63:0] d);
        logic [63:0] r;
        for (int j = 0; j < 63; j++) begin
            r[j] = d[(16 * j) % 63];
        end
        r[63] = d[63];
        return r;
    endfunction

    function automatic logic [63:0] inv_s_layer(input logic [63:0] d);
        logic [63:0] r;
        for (int n = 0; n < 16; n++) begin
            r[4*n +: 4] = inv_sbox(d[4*n +: 4]);
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Datapath state
    // ------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [63:0] dreg_q,  dreg_d;
    logic [79:0] kreg_q,  kreg_d;
    logic [4:0]  rc_q,    rc_d;
    logic [63:0] odat_q,  odat_d;
    logic        done_q,  done_d;
    logic        busy_q,  busy_d;

    logic [79:0] k_fwd;
    logic [79:0] k_inv;
    logic [63:0] round_out;
    logic        cache_wr;
    logic        cache_hit;
    logic [79:0] cache_k32;

    assign k_fwd     = key_fwd(kreg_q, rc_q);
    assign k_inv     = key_inv(kreg_q, rc_q);
    assign round_out = inv_s_layer(inv_p(dreg_q)) ^ k_inv[79:16];

    always_comb begin
        state_d  = state_q;
        dreg_d   = dreg_q;
        kreg_d   = kreg_q;
        rc_d     = rc_q;
        odat_d   = odat_q;
        done_d   = done_q;
        busy_d   = busy_q;
        cache_wr = 1'b0;

        if (bus.load) begin
            // A load always restarts, whatever job is in flight.
            done_d = 1'b0;
            busy_d = 1'b1;
            if (cache_hit) begin
                kreg_d  = cache_k32;
                dreg_d  = bus.idat ^ cache_k32[79:16];
                rc_d    = 5'd31;
                state_d = DECRYPT;
            end else begin
                kreg_d  = bus.key;
                dreg_d  = bus.idat;
                rc_d    = 5'd1;
                state_d = EXPAND;
            end
        end else begin
            case (state_q)
                EXPAND: begin
                    kreg_d = k_fwd;
                    if (rc_q == 5'd31) begin
                        // k_fwd is K32 here: whiten and start unwinding.
                        dreg_d   = dreg_q ^ k_fwd[79:16];
                        state_d  = DECRYPT;
                        cache_wr = 1'b1;
                    end else begin
                        rc_d = rc_q + 5'd1;
                    end
                end
                DECRYPT: begin
                    kreg_d = k_inv;
                    dreg_d = round_out;
                    if (rc_q == 5'd1) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        odat_d  = round_out;
                    end else begin
                        rc_d = rc_q - 5'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            dreg_q  <= '0;
            kreg_q  <= '0;
            rc_q    <= '0;
            odat_q  <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dreg_q  <= dreg_d;
            kreg_q  <= kreg_d;
            rc_q    <= rc_d;
            odat_q  <= odat_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    // ------------------------------------------------------------------
    // Single-entry K32 cache
    // ------------------------------------------------------------------
    generate
        if (KEY_CACHE != 0) begin : g_cache
            logic [79:0] lkey_q, lkey_d;   // key of the job being expanded
            logic [79:0] ckey_q, ckey_d;
            logic [79:0] ck32_q, ck32_d;
            logic        cvalid_q, cvalid_d;

            always_comb begin
                lkey_d   = lkey_q;
                ckey_d   = ckey_q;
                ck32_d   = ck32_q;
                cvalid_d = cvalid_q;
                if (bus.load) begin
                    lkey_d = bus.key;
                end
                // Only a completed expansion updates the entry, so an
                // aborted job can never leave a stale K32 behind.
                if (cache_wr) begin
                    ckey_d   = lkey_q;
                    ck32_d   = k_fwd;
                    cvalid_d = 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    lkey_q   <= '0;
                    ckey_q   <= '0;
                    ck32_q   <= '0;
                    cvalid_q <= 1'b0;
                end else begin
                    lkey_q   <= lkey_d;
                    ckey_q   <= ckey_d;
                    ck32_q   <= ck32_d;
                    cvalid_q <= cvalid_d;
                end
            end

            assign cache_hit = cvalid_q && (bus.key == ckey_q);
            assign cache_k32 = ck32_q;
        end else begin : g_no_cache
            assign cache_hit = 1'b0;
            assign cache_k32 = '0;
        end
    endgenerate

    assign bus.odat = odat_q;
    assign bus.done = done_q;
    assign bus.busy = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_present_decrypt.sv
`default_nettype none
// ============================================================================
//  Module      : tb_present_decrypt
//  Description : Scoreboard bench for present_decrypt. Two instances: one
//                with the key cache, one without. Stimulus pushes expected
//                plaintext and latency; a monitor pops on each rising done.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_present_decrypt;

    localparam logic [79:0] K0 = 80'h0;
    localparam logic [79:0] K1 = 80'hffffffffffffffffffff;
    localparam logic [63:0] P0 = 64'h0;
    localparam logic [63:0] P1 = 64'hffffffffffffffff;
    localparam logic [63:0] C00 = 64'h5579c1387b228445;  // P0 under K0
    localparam logic [63:0] C01 = 64'he72c46c0f5945049;  // P0 under K1
    localparam logic [63:0] C10 = 64'ha112ffc72f68417b;  // P1 under K0
    localparam logic [63:0] C11 = 64'h3333dcd3213210d2;  // P1 under K1

    typedef struct {
        logic [63:0] odat;
        int          lat;
        int          dut;
        int          load_edge;
    } exp_t;

    logic clk;
    logic reset0;
    logic reset1;
    int   cyc;
    int   checks;
    int   errors;
    exp_t sb[$];

    logic       prev_done [2];
    logic       prev_busy [2];
    logic       m_done;
    logic       m_busy;
    logic [63:0] m_odat;
    exp_t       m_e;

    present_decrypt_if bus0 ();
    present_decrypt_if bus1 ();

    present_decrypt #(.KEY_CACHE(1)) u_dut0 (
        .clk   (clk),
        .reset (reset0),
        .bus   (bus0.slave)
    );

    present_decrypt #(.KEY_CACHE(0)) u_dut1 (
        .clk   (clk),
        .reset (reset1),
        .bus   (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int d, input logic [63:0] got,
                       input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s dut%0d got %h want %h", name, d, got, want);
        end
    endtask

    // Monitor: every rising done must match the oldest outstanding job.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            m_done = (d == 0) ? bus0.done : bus1.done;
            m_busy = (d == 0) ? bus0.busy : bus1.busy;
            m_odat = (d == 0) ? bus0.odat : bus1.odat;
            if (m_done === 1'b1 && prev_done[d] !== 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done dut%0d odat %h", d, m_odat);
                end else begin
                    m_e = sb.pop_front();
                    chk("done_dut", d, 64'(d), 64'(m_e.dut));
                    chk("odat", d, m_odat, m_e.odat);
                    chk("latency", d, 64'(cyc - m_e.load_edge), 64'(m_e.lat));
                    chk("busy_fall", d, {62'd0, m_busy, prev_busy[d]}, 64'd1);
                end
            end
            prev_done[d] = m_done;
            prev_busy[d] = m_busy;
        end
    end

    // Drive one load strobe; optionally register the job as expected to finish.
    task automatic start_job(input int d, input logic [63:0] ct, input logic [79:0] k,
                             input bit expect_done, input logic [63:0] pt, input int lat);
        exp_t e;
        @(negedge clk);
        if (d == 0) begin
            bus0.load = 1'b1; bus0.idat = ct; bus0.key = k;
        end else begin
            bus1.load = 1'b1; bus1.idat = ct; bus1.key = k;
        end
        if (expect_done) begin
            e.odat = pt; e.lat = lat; e.dut = d; e.load_edge = cyc + 1;
            sb.push_back(e);
        end
        @(negedge clk);
        bus0.load = 1'b0;
        bus1.load = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout waiting for done, %0d jobs outstanding want 0", sb.size());
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic job(input int d, input logic [63:0] ct, input logic [79:0] k,
                       input logic [63:0] pt, input int lat);
        start_job(d, ct, k, 1'b1, pt, lat);
        wait_idle();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        prev_done[0] = 1'b0; prev_done[1] = 1'b0;
        prev_busy[0] = 1'b0; prev_busy[1] = 1'b0;
        bus0.load = 1'b0; bus0.idat = '0; bus0.key = '0;
        bus1.load = 1'b0; bus1.idat = '0; bus1.key = '0;
        reset0 = 1'b1;
        reset1 = 1'b1;
        repeat (3) @(negedge clk);
        reset0 = 1'b0;
        reset1 = 1'b0;
        chk("rst_odat", 0, bus0.odat, 64'h0);
        chk("rst_done", 0, 64'(bus0.done), 64'h0);
        chk("rst_busy", 0, 64'(bus0.busy), 64'h0);
        chk("rst_done", 1, 64'(bus1.done), 64'h0);

        // Alternating misses and hits on the cached core.
        job(0, C00, K0, P0, 62);
        job(0, C01, K1, P0, 62);
        job(0, C11, K1, P1, 31);
        job(0, C10, K0, P1, 62);
        job(0, C00, K0, P0, 31);
        job(0, C01, K1, P0, 62);

        // Abort during EXPAND: A's expansion must not reach the cache.
        start_job(0, C00, K0, 1'b0, P0, 0);
        repeat (18) @(negedge clk);
        start_job(0, C11, K1, 1'b1, P1, 31);
        wait_idle();
        job(0, C10, K0, P1, 62);

        // Abort during DECRYPT: B replaces the entry A wrote.
        start_job(0, C01, K1, 1'b0, P0, 0);
        repeat (43) @(negedge clk);
        start_job(0, C10, K0, 1'b1, P1, 62);
        wait_idle();
        job(0, C00, K0, P0, 31);
        job(0, C11, K1, P1, 62);

        // Reset mid-job clears outputs and the cache.
        start_job(0, C00, K0, 1'b0, P0, 0);
        repeat (38) @(negedge clk);
        reset0 = 1'b1;
        @(negedge clk);
        reset0 = 1'b0;
        chk("midrst_odat", 0, bus0.odat, 64'h0);
        chk("midrst_done", 0, 64'(bus0.done), 64'h0);
        chk("midrst_busy", 0, 64'(bus0.busy), 64'h0);
        job(0, C10, K0, P1, 62);

        // Reset and load together: reset wins, core stays idle.
        @(negedge clk);
        reset0 = 1'b1;
        bus0.load = 1'b1; bus0.idat = C11; bus0.key = K1;
        @(negedge clk);
        reset0 = 1'b0;
        bus0.load = 1'b0;
        chk("rstload_busy", 0, 64'(bus0.busy), 64'h0);
        chk("rstload_done", 0, 64'(bus0.done), 64'h0);
        chk("rstload_odat", 0, bus0.odat, 64'h0);
        repeat (5) @(negedge clk);
        chk("rstload_idle_busy", 0, 64'(bus0.busy), 64'h0);
        chk("rstload_idle_done", 0, 64'(bus0.done), 64'h0);
        job(0, C11, K1, P1, 62);

        // Cache-less core: a repeated key still takes the full latency.
        job(1, C00, K0, P0, 62);
        job(1, C10, K0, P1, 62);
        job(1, C10, K0, P1, 62);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
